// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: one shift-add (MUL/MULHU) or restoring
// shift-subtract (DIVU/REMU) step per clock, DWIDTH steps per operation.
module muldiv_unit #(
   parameter int DWIDTH = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        op,
   input  logic [DWIDTH-1:0] a,
   input  logic [DWIDTH-1:0] b,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DWIDTH-1:0] result,
   output logic              busy
);

   localparam int CW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [CW-1:0]       r_cnt;
   logic                r_hi_sel;
   logic [DWIDTH-1:0]   r_a;
   logic [DWIDTH-1:0]   r_b;
   logic [2*DWIDTH-1:0] r_prod;

   logic                w_accept;
   logic                w_last;
   logic [DWIDTH:0]     w_sum;
   logic [DWIDTH:0]     w_shift;
   logic [DWIDTH-1:0]   w_diff;
   logic                w_ge;

   assign w_accept = req_valid && (r_state == S_IDLE);
   assign w_last   = (r_cnt == CW'(DWIDTH - 1));

   // Multiply: upper half accumulates the multiplicand, whole register shifts right.
   assign w_sum = {1'b0, r_prod[2*DWIDTH-1:DWIDTH]} + (r_prod[0] ? {1'b0, r_a} : '0);

   // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
   assign w_shift = {r_prod[2*DWIDTH-1:DWIDTH], r_prod[DWIDTH-1]};
   assign w_ge    = (w_shift >= {1'b0, r_b});
   assign w_diff  = w_shift[DWIDTH-1:0] - r_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (req_valid)  w_state_next = op[1] ? S_DIV : S_MUL;
         S_MUL:   if (w_last)     w_state_next = S_DONE;
         S_DIV:   if (w_last)     w_state_next = S_DONE;
         S_DONE:  if (resp_ready) w_state_next = S_IDLE;
         default:                 w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_hi_sel <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_prod   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_cnt    <= '0;
                  r_hi_sel <= op[0];
                  r_a      <= a;
                  r_b      <= b;
                  r_prod   <= {{DWIDTH{1'b0}}, (op[1] ? a : b)};
               end
            end
            S_MUL: begin
               r_prod <= {w_sum, r_prod[DWIDTH-1:1]};
               r_cnt  <= r_cnt + CW'(1);
            end
            S_DIV: begin
               r_prod <= {(w_ge ? w_diff : w_shift[DWIDTH-1:0]), r_prod[DWIDTH-2:0], w_ge};
               r_cnt  <= r_cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   // Low half carries product-low or quotient, high half product-high or remainder.
   assign req_ready  = (r_state == S_IDLE);
   assign busy       = (r_state != S_IDLE);
   assign resp_valid = (r_state == S_DONE);
   assign result     = resp_valid ? (r_hi_sel ? r_prod[2*DWIDTH-1:DWIDTH] : r_prod[DWIDTH-1:0])
                                  : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: expected results queued at request time and
// compared when the response appears, with latency, handshake and reset checks.
module tb_muldiv_unit;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         resp_valid;
   logic         resp_ready = 1'b0;
   logic [W-1:0] result;
   logic         busy;

   int checks = 0;
   int failures = 0;
   logic [W-1:0] sb[$];

   muldiv_unit #(.DWIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .op         (op),
      .a          (a),
      .b          (b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .result     (result),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      logic [2*W-1:0] p;
      p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
      case (o)
         2'b00:   return p[W-1:0];
         2'b01:   return p[2*W-1:W];
         2'b10:   return (y == '0) ? {W{1'b1}} : x / y;
         default: return (y == '0) ? x : x % y;
      endcase
   endfunction

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full transaction: drive, count latency, compare, optional backpressure, consume.
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit scramble, input int hold);
      int edges;
      bit got;
      logic [W-1:0] exp;
      @(negedge clk);
      op = o; a = x; b = y; req_valid = 1'b1;
      check("req_ready_idle", W'(req_ready), W'(1));
      sb.push_back(model(o, x, y));
      @(posedge clk);
      edges = 1;
      got = 1'b0;
      @(negedge clk);
      if (!scramble) req_valid = 1'b0;
      check("busy_after_accept", W'(busy), W'(1));
      check("req_ready_low_busy", W'(req_ready), W'(0));
      check("result_zero_busy", result, '0);
      for (int i = 0; i < 100 && !got; i++) begin
         if (resp_valid) begin
            got = 1'b1;
         end else begin
            if (scramble) begin
               a = $urandom; b = $urandom; op = 2'($urandom);
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
         end
      end
      check("latency", W'(edges), W'(W + 1));
      exp = (sb.size() > 0) ? sb.pop_front() : '0;
      check("result", result, exp);
      $display("op=%0d a=%h b=%h result=%h expected=%h latency=%0d", o, x, y, result, exp, edges);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("hold_valid", W'(resp_valid), W'(1));
         check("hold_result", result, exp);
         check("hold_req_ready", W'(req_ready), W'(0));
         check("hold_busy", W'(busy), W'(1));
      end
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      req_valid = 1'b0;
      check("after_consume_valid", W'(resp_valid), W'(0));
      check("after_consume_req_ready", W'(req_ready), W'(1));
      check("after_consume_busy", W'(busy), W'(0));
      check("after_consume_result", result, '0);
   endtask

   initial begin
      bit seen;
      #1 rst_n = 1'b0;
      #1;
      check("reset_req_ready", W'(req_ready), W'(1));
      check("reset_resp_valid", W'(resp_valid), W'(0));
      check("reset_busy", W'(busy), W'(0));
      check("reset_result", result, '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_op(2'b00, 32'hFFFF_FFFF, 32'h2, 1'b0, 0);
      run_op(2'b01, 32'hFFFF_FFFF, 32'h2, 1'b0, 0);
      run_op(2'b10, 32'd100, 32'd7, 1'b0, 0);
      run_op(2'b11, 32'd100, 32'd7, 1'b0, 0);
      run_op(2'b10, 32'h1234, 32'h0, 1'b0, 0);
      run_op(2'b11, 32'h1234, 32'h0, 1'b0, 0);
      run_op(2'b01, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 10);
      for (int i = 0; i < 8; i++) begin
         run_op(2'(i), $urandom, (i == 6) ? 32'h0000_0013 : $urandom, 1'b0, 0);
      end
      run_op(2'b11, 32'hFFFF_FFFF, 32'h0001_0000, 1'b1, 2);
      run_op(2'b00, 32'h0001_2345, 32'h0000_0F0F, 1'b1, 0);

      // Abort a divide after its 15th step with an asynchronous reset.
      @(negedge clk);
      op = 2'b10; a = 32'd1000; b = 32'd3; req_valid = 1'b1;
      sb.push_back(model(2'b10, 32'd1000, 32'd3));
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (15) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_resp_valid", W'(resp_valid), W'(0));
      check("abort_busy", W'(busy), W'(0));
      check("abort_req_ready", W'(req_ready), W'(1));
      check("abort_result", result, '0);
      sb.delete();
      req_valid = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("no_accept_in_reset", W'(busy), W'(0));
      req_valid = 1'b0;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (resp_valid || busy) seen = 1'b1;
      end
      check("no_resp_after_abort", W'(seen), W'(0));
      run_op(2'b00, 32'd3, 32'd5, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, meaning operand and result width.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid  input  1  request offered.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port op  input  2  operation: 00 MUL (low half), 01 MULHU (high half), 10 DIVU, 11 REMU.
REQ-007 SHALL have port a  input  DWIDTH  first operand (multiplicand or dividend), unsigned.
REQ-008 SHALL have port b  input  DWIDTH  second operand (multiplier or divisor), unsigned.
REQ-009 SHALL have port resp_valid  output  1  result available.
REQ-010 SHALL have port resp_ready  input  1  consumer takes result.
REQ-011 SHALL have port result  output  DWIDTH  operation result.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-014 SHALL drive req_ready high only in IDLE; a request is accepted on a rising edge where req_valid and req_ready are both high.
REQ-015 SHALL on accept latch op, a and b, clear the iteration counter, and move to MUL (op[1]=0) or DIV (op[1]=1).
REQ-016 SHALL ignore a, b and op changes after the accepting edge until the next accept.
REQ-017 SHALL in MUL perform one shift-add step per cycle into a 2*DWIDTH-bit product register: exactly DWIDTH steps.
REQ-018 SHALL in DIV perform one restoring shift-subtract step per cycle, producing quotient and remainder: exactly DWIDTH steps.
REQ-019 SHALL move to DONE on the edge that completes step DWIDTH; resp_valid SHALL first be high in the cycle following DWIDTH+1 rising edges from and including the accepting edge, for every op and operand value.
REQ-020 SHALL drive result = product[DWIDTH-1:0] for MUL, product[2*DWIDTH-1:DWIDTH] for MULHU, quotient for DIVU, remainder for REMU.
REQ-021 SHALL for b = 0 return quotient all-ones and remainder = a, with unchanged latency.
REQ-022 SHALL hold resp_valid and result stable in DONE until resp_ready is high on a rising edge, then return to IDLE.
REQ-023 SHALL not accept a new request in the cycle the response is consumed; req_ready rises the cycle after.
REQ-024 SHALL drive result = 0 whenever resp_valid is low.
REQ-025 SHALL compute all arithmetic modulo its stated width; no overflow flag.

Reset
REQ-026 SHALL on rst_n low enter IDLE immediately, independent of clk, with req_ready=1 after reset, resp_valid=0, busy=0, result=0, counter and datapath registers cleared.
REQ-027 SHALL abort any operation in progress, or any pending response, when rst_n falls; no response for it is ever produced.
REQ-028 SHALL accept no request while rst_n is low; first accept possible on the first rising edge with rst_n high.

Verification
REQ-029 SHALL pass: MUL a=0xFFFF_FFFF b=0x2 -> result 0xFFFF_FFFE; MULHU same operands -> 0x0000_0001; each resp_valid exactly 33 edges after accept.
REQ-030 SHALL pass: DIVU a=100 b=7 -> 14; REMU a=100 b=7 -> 2.
REQ-031 SHALL pass: DIVU a=0x1234 b=0 -> 0xFFFF_FFFF; REMU a=0x1234 b=0 -> 0x1234; latency 33.
REQ-032 SHALL pass: resp_ready held low 10 cycles after resp_valid -> result stable, req_ready low, busy high throughout; release -> IDLE next edge, req_ready high.
REQ-033 SHALL pass: rst_n pulsed low mid-DIV at step 15 -> outputs reach reset values without a clock edge; no resp_valid afterwards; next request MUL 3*5 -> 15.
REQ-034 SHALL pass: operands changed every cycle after accept with req_valid held high -> result uses latched values; second request accepted only after response consumed.
